// File: rtl/seg7_pkg.sv
// Shared constants, payload types and helpers for the seven-segment scan driver.
package seg7_pkg;

  localparam int unsigned NUM_DIG = 4;
  localparam int unsigned BCD_W   = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned SLOT_W  = $clog2(NUM_DIG);
  localparam int unsigned BUS_W   = NUM_DIG * BCD_W;

  // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;

  // Everything the display pins carry in one cycle.
  typedef struct packed {
    logic [SEG_W-1:0]   seg_n;
    logic               dp_n;
    logic [NUM_DIG-1:0] an_n;
  } disp_t;

  localparam disp_t DISP_OFF = '{seg_n: SEG_OFF, dp_n: 1'b1, an_n: '1};

  // Active-low one-hot anode enable for a slot.
  function automatic logic [NUM_DIG-1:0] anode_n(input logic [SLOT_W-1:0] slot);
    return ~(NUM_DIG'(1) << slot);
  endfunction

endpackage

// File: rtl/seg7_scan_bcd_to_seg7.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg_n_c
);

  // Pattern lookup, dash for codes 10..15.
  always_comb begin
    seg_n_c = SEG_DASH;
    case (bcd)
      4'd0:    seg_n_c = SEG_0;
      4'd1:    seg_n_c = SEG_1;
      4'd2:    seg_n_c = SEG_2;
      4'd3:    seg_n_c = SEG_3;
      4'd4:    seg_n_c = SEG_4;
      4'd5:    seg_n_c = SEG_5;
      4'd6:    seg_n_c = SEG_6;
      4'd7:    seg_n_c = SEG_7;
      4'd8:    seg_n_c = SEG_8;
      4'd9:    seg_n_c = SEG_9;
      default: seg_n_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with frame-coherent input snapshot,
// ghosting guard window, optional leading-zero blanking and dash for invalid BCD.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [BUS_W-1:0]     bcd_in,
  input  logic [NUM_DIG-1:0]   dp_in,
  input  logic                 lz_blank,
  output logic [SEG_W-1:0]     seg_n,
  output logic                 dp_n,
  output logic [NUM_DIG-1:0]   an_n,
  output logic                 frame_done
);

  localparam int unsigned     CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIG - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [BUS_W-1:0]   shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIG-1:0] shadow_dp_q, shadow_dp_d;
  disp_t              disp_q, disp_d;
  logic               frame_done_q, frame_done_d;

  logic [BCD_W-1:0]   dig [NUM_DIG];
  logic [NUM_DIG-1:0] upper_zero;
  logic               zero_run;
  logic [BCD_W-1:0]   cur_dig;
  logic               cur_dp;
  logic               cur_blank;
  logic [SEG_W-1:0]   dec_seg_c;

  // Split the shadow word into per-digit nibbles.
  always_comb begin
    for (int k = 0; k < int'(NUM_DIG); k++) begin
      dig[k] = shadow_bcd_q[k*BCD_W +: BCD_W];
    end
  end

  // upper_zero[k] is set when digit k and every more significant digit are zero.
  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int k = int'(NUM_DIG) - 1; k >= 0; k--) begin
      zero_run      = zero_run & (dig[k] == '0);
      upper_zero[k] = zero_run;
    end
  end

  // Select the digit of the active slot; digit 0 is never a leading zero.
  always_comb begin
    cur_dig   = dig[slot_q];
    cur_dp    = shadow_dp_q[slot_q];
    cur_blank = lz_blank && (slot_q != '0) && upper_zero[slot_q];
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd     (cur_dig),
    .seg_n_c (dec_seg_c)
  );

  // Prescaler, slot counter and start-of-frame snapshot.
  always_comb begin
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    if (!en) begin
      cnt_d  = '0;
      slot_d = '0;
    end else begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        slot_d = slot_q + SLOT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if ((cnt_q == '0) && (slot_q == '0)) begin
        shadow_bcd_d = bcd_in;
        shadow_dp_d  = dp_in;
      end
    end
  end

  // Next display word: dark in the guard window, otherwise the slot digit,
  // with a blanked leading zero keeping its anode only to show a requested dp.
  always_comb begin
    disp_d       = DISP_OFF;
    frame_done_d = 1'b0;
    if (en) begin
      frame_done_d = (slot_q == SLOT_LAST) && (cnt_q == CNT_MAX);
      if (cnt_q >= BLANK_LIM) begin
        disp_d.dp_n = ~cur_dp;
        if (cur_blank) begin
          disp_d.an_n = cur_dp ? anode_n(slot_q) : '1;
        end else begin
          disp_d.seg_n = dec_seg_c;
          disp_d.an_n  = anode_n(slot_q);
        end
      end
    end
  end

  // State and output registers; reset forces the display dark at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      slot_q       <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      disp_q       <= DISP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_q       <= disp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = disp_q.seg_n;
  assign dp_n       = disp_q.dp_n;
  assign an_n       = disp_q.an_n;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: two instances (4/1 and 5/2 timing) against
// a frame-time behavioural model, plus directed literal expectations.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        lz_blank;

  logic [6:0] seg_n0, seg_n1;
  logic       dp_n0, dp_n1;
  logic [3:0] an_n0, an_n1;
  logic       fd0, fd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan #(.SCAN_DIV(4), .BLANK_CYC(1)) dut0 (
    .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg_n(seg_n0), .dp_n(dp_n0), .an_n(an_n0),
    .frame_done(fd0)
  );

  seg7_scan #(.SCAN_DIV(5), .BLANK_CYC(2)) dut1 (
    .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg_n(seg_n1), .dp_n(dp_n1), .an_n(an_n1),
    .frame_done(fd1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pattern(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Model: t = cycles since the current frame sequence began.
  int         t      [2];
  logic [15:0] sh_bcd [2];
  logic [3:0]  sh_dp  [2];
  logic [6:0]  e_seg  [2];
  logic        e_dp   [2];
  logic [3:0]  e_an   [2];
  logic        e_fd   [2];

  always @(posedge clk or negedge rst) begin
    int div, blk, cnt, slot, d;
    logic dpb;
    logic [15:0] upper;
    for (int i = 0; i < 2; i++) begin
      div = (i == 0) ? 4 : 5;
      blk = (i == 0) ? 1 : 2;
      if (!rst) begin
        t[i] = 0; sh_bcd[i] = 16'h0; sh_dp[i] = 4'h0;
        e_seg[i] = 7'h7F; e_dp[i] = 1'b1; e_an[i] = 4'hF; e_fd[i] = 1'b0;
      end else if (!en) begin
        t[i] = 0;
        e_seg[i] = 7'h7F; e_dp[i] = 1'b1; e_an[i] = 4'hF; e_fd[i] = 1'b0;
      end else begin
        cnt  = t[i] % div;
        slot = (t[i] / div) % 4;
        e_fd[i]  = (t[i] == 4 * div - 1);
        e_seg[i] = 7'h7F; e_dp[i] = 1'b1; e_an[i] = 4'hF;
        if (cnt >= blk) begin
          upper = 16'(sh_bcd[i] >> (4 * slot));
          d     = int'(upper[3:0]);
          dpb   = sh_dp[i][slot];
          e_dp[i] = ~dpb;
          if (lz_blank && slot > 0 && upper == 16'h0) begin
            e_an[i] = dpb ? ~4'(1 << slot) : 4'hF;
          end else begin
            e_seg[i] = pattern(d);
            e_an[i]  = ~4'(1 << slot);
          end
        end
        if (t[i] == 0) begin
          sh_bcd[i] = bcd_in;
          sh_dp[i]  = dp_in;
        end
        t[i] = (t[i] + 1) % (4 * div);
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("seg0", 32'(seg_n0), 32'(e_seg[0]));
    check("dp0",  32'(dp_n0),  32'(e_dp[0]));
    check("an0",  32'(an_n0),  32'(e_an[0]));
    check("fd0",  32'(fd0),    32'(e_fd[0]));
    check("seg1", 32'(seg_n1), 32'(e_seg[1]));
    check("dp1",  32'(dp_n1),  32'(e_dp[1]));
    check("an1",  32'(an_n1),  32'(e_an[1]));
    check("fd1",  32'(fd1),    32'(e_fd[1]));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One dark cycle to put both instances back at cnt=0, slot=0.
  task automatic restart();
    en = 1'b0;
    tick();
    en = 1'b1;
  endtask

  int fd_cnt, dark, lit;

  initial begin
    rst = 1'b1; en = 1'b1; bcd_in = 16'h1234; dp_in = 4'h0; lz_blank = 1'b0;
    #1 rst = 1'b0;
    repeat (3) begin
      tick();
      check("an_in_reset", 32'(an_n0), 32'hF);
    end
    rst = 1'b1;

    // Reset and count
    fd_cnt = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (fd0) fd_cnt++;
      if (i == 1) check("first_out_dark", 32'(an_n0), 32'hF);
      if (i >= 2 && i <= 4) begin
        check("slot0_an",  32'(an_n0),  32'(4'b1110));
        check("slot0_seg", 32'(seg_n0), 32'(7'b0011001));
      end
      if (i == 6)  check("slot1_seg", 32'({an_n0, seg_n0}), 32'({4'b1101, 7'b0110000}));
      if (i == 10) check("slot2_seg", 32'({an_n0, seg_n0}), 32'({4'b1011, 7'b0100100}));
      if (i == 14) check("slot3_seg", 32'({an_n0, seg_n0}), 32'({4'b0111, 7'b1111001}));
      if (i == 16) check("fd_at_16", 32'(fd0), 32'd1);
    end
    check("fd_count", 32'(fd_cnt), 32'd4);

    // Snapshot coherence
    bcd_in = 16'h0999;
    restart();
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 9) bcd_in = 16'h1000;
      if (i == 14) check("coh_old_d3", 32'({an_n0, seg_n0}), 32'({4'b0111, 7'b1000000}));
      if (i == 18 || i == 22 || i == 26) check("coh_new_zero", 32'(seg_n0), 32'(7'b1000000));
      if (i == 30) check("coh_new_d3", 32'({an_n0, seg_n0}), 32'({4'b0111, 7'b1111001}));
    end

    // Leading-zero blanking
    bcd_in = 16'h0050; dp_in = 4'b0100; lz_blank = 1'b1;
    restart();
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 2)  check("lz_d0", 32'({an_n0, seg_n0, dp_n0}), 32'({4'b1110, 7'b1000000, 1'b1}));
      if (i == 6)  check("lz_d1", 32'({an_n0, seg_n0, dp_n0}), 32'({4'b1101, 7'b0010010, 1'b1}));
      if (i == 10) check("lz_d2", 32'({an_n0, seg_n0, dp_n0}), 32'({4'b1011, 7'h7F, 1'b0}));
      if (i >= 13) check("lz_d3_off", 32'(an_n0), 32'hF);
    end

    // Invalid code
    bcd_in = 16'h00A0; dp_in = 4'h0; lz_blank = 1'b0;
    restart();
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6)  check("dash", 32'({an_n0, seg_n0}), 32'({4'b1101, 7'b0111111}));
      if (i == 10) check("zero_unblanked", 32'({an_n0, seg_n0}), 32'({4'b1011, 7'b1000000}));
    end

    // Enable drop mid-frame, fresh snapshot on return
    bcd_in = 16'h1234;
    restart();
    repeat (10) tick();
    check("en_slot2_lit", 32'(an_n0), 32'(4'b1011));
    en = 1'b0;
    bcd_in = 16'h5678;
    tick();
    check("en_dark", 32'({an_n0, seg_n0, dp_n0, an_n1}), 32'({4'hF, 7'h7F, 1'b1, 4'hF}));
    en = 1'b1;
    tick();
    check("en_first_blank", 32'(an_n0), 32'hF);
    tick();
    check("en_fresh_slot0", 32'({an_n0, seg_n0}), 32'({4'b1110, 7'b0000000}));

    // Asynchronous reset mid-slot
    restart();
    repeat (3) tick();
    check("pre_rst_lit", 32'(an_n0), 32'(4'b1110));
    #1 rst = 1'b0;
    #1 check("rst_async", 32'({an_n0, seg_n0, dp_n0, an_n1}), 32'({4'hF, 7'h7F, 1'b1, 4'hF}));
    bcd_in = 16'h4321;
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("rst_fresh_slot0", 32'({an_n0, seg_n0}), 32'({4'b1110, 7'b1111001}));

    // Blank window on the 5/2 instance
    restart();
    dark = 0; lit = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (an_n1 == 4'hF) begin
        dark++;
        check("dark_seg_off", 32'({seg_n1, dp_n1}), 32'({7'h7F, 1'b1}));
      end else begin
        lit++;
      end
    end
    check("dark_cycles", 32'(dark), 32'd8);
    check("lit_cycles",  32'(lit),  32'd12);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 99) < 12) begin
        for (int k = 0; k < 4; k++) begin
          bcd_in[k*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        end
      end
      if ($urandom_range(0, 99) < 8) dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 2) lz_blank = ~lz_blank;
      if ($urandom_range(0, 99) < 2) en = ~en;
      if ($urandom_range(0, 999) < 2) begin
        #1 rst = 1'b0;
        tick();
        rst = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
